// File: rtl/toff_cascade_engine.sv
// Sequential reversible-logic evaluator: applies one NOT/CNOT/CCNOT gate per clock from a program RAM.
// Optional single-step gating is enabled by defining TOFF_STEP_EN (adds step_in).
module toff_cascade_engine #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned IDX_W  = $clog2(WIDTH),
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   prog_we_in,
  input  logic [ADDR_W-1:0]      prog_addr_in,
  input  logic [2+3*IDX_W-1:0]   prog_gate_in,
  input  logic [ADDR_W:0]        num_gates_in,
  input  logic                   rev_in,
  input  logic                   start_in,
`ifdef TOFF_STEP_EN
  input  logic                   step_in,
`endif
  input  logic [WIDTH-1:0]       state_in,
  output logic [WIDTH-1:0]       state_out,
  output logic                   busy_out,
  output logic                   done_out,
  output logic                   err_out
);

  localparam int unsigned GateW = 2 + 3 * IDX_W;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [IDX_W:0]  WidthL = (IDX_W + 1)'(WIDTH);
  localparam logic [ADDR_W:0] DepthL = (ADDR_W + 1)'(DEPTH);

  logic [GateW-1:0]  mem_q [DEPTH];
  logic [1:0]        st_q, st_d;
  logic [WIDTH-1:0]  line_q, line_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              rev_q, rev_d;
  logic              err_q, err_d;
  logic              step;

`ifdef TOFF_STEP_EN
  assign step = step_in;
`else
  assign step = 1'b1;
`endif

  // Current gate decode
  logic [GateW-1:0] gate;
  logic             ca_en, cb_en;
  logic [IDX_W-1:0] ca_idx, cb_idx, t_idx;
  logic             illegal;
  logic             ctl;

  assign gate   = mem_q[ptr_q];
  assign ca_en  = gate[GateW-1];
  assign cb_en  = gate[GateW-2];
  assign ca_idx = gate[3*IDX_W-1 -: IDX_W];
  assign cb_idx = gate[2*IDX_W-1 -: IDX_W];
  assign t_idx  = gate[IDX_W-1:0];

  assign illegal = ({1'b0, t_idx} >= WidthL)
                 | (ca_en & (({1'b0, ca_idx} >= WidthL) | (ca_idx == t_idx)))
                 | (cb_en & (({1'b0, cb_idx} >= WidthL) | (cb_idx == t_idx)));

  // A disabled control reads as constant 1
  assign ctl = (~ca_en | line_q[ca_idx]) & (~cb_en | line_q[cb_idx]);

  logic [ADDR_W:0] n_clamp;
  assign n_clamp = (num_gates_in > DepthL) ? DepthL : num_gates_in;

  always_comb begin
    st_d   = st_q;
    line_d = line_q;
    ptr_d  = ptr_q;
    rem_d  = rem_q;
    rev_d  = rev_q;
    err_d  = err_q;
    case (st_q)
      StIdle: begin
        if (start_in) begin
          line_d = state_in;
          rev_d  = rev_in;
          err_d  = 1'b0;
          rem_d  = n_clamp;
          // Low bits of DEPTH are zero, so the wrap yields DEPTH-1 when clamped
          ptr_d  = rev_in ? (n_clamp[ADDR_W-1:0] - 1'b1) : '0;
          st_d   = (n_clamp == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (step) begin
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            line_d[t_idx] = line_q[t_idx] ^ ctl;
          end
          ptr_d = rev_q ? (ptr_q - 1'b1) : (ptr_q + 1'b1);
          rem_d = rem_q - 1'b1;
          if (rem_q == (ADDR_W + 1)'(1)) begin
            st_d = StDone;
          end
        end
      end
      StDone:  st_d = StIdle;
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      st_q   <= StIdle;
      line_q <= '0;
      ptr_q  <= '0;
      rem_q  <= '0;
      rev_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      line_q <= line_d;
      ptr_q  <= ptr_d;
      rem_q  <= rem_d;
      rev_q  <= rev_d;
      err_q  <= err_d;
    end
  end

  // Program memory survives reset; writes are dropped while running
  always_ff @(posedge clk_in) begin
    if (prog_we_in && (st_q != StRun)) begin
      mem_q[prog_addr_in] <= prog_gate_in;
    end
  end

  assign state_out = line_q;
  assign busy_out  = (st_q == StRun);
  assign done_out  = (st_q == StDone);
  assign err_out   = err_q;

endmodule

// File: tb/tb_toff_cascade_engine.sv
// Directed self-checking bench for toff_cascade_engine (WIDTH=8, DEPTH=16).
module tb_toff_cascade_engine;

  logic        clk;
  logic        rst;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [10:0] prog_gate;
  logic [4:0]  num_gates;
  logic        rev;
  logic        start;
  logic        step;
  logic [7:0]  state_in;
  logic [7:0]  state_out;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fails  = 0;

  toff_cascade_engine #(.WIDTH(8), .DEPTH(16)) dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .prog_we_in   (prog_we),
    .prog_addr_in (prog_addr),
    .prog_gate_in (prog_gate),
    .num_gates_in (num_gates),
    .rev_in       (rev),
    .start_in     (start),
`ifdef TOFF_STEP_EN
    .step_in      (step),
`endif
    .state_in     (state_in),
    .state_out    (state_out),
    .busy_out     (busy),
    .done_out     (done),
    .err_out      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] g(input logic ae, input logic be, input logic [2:0] a,
                                    input logic [2:0] b, input logic [2:0] t);
    return {ae, be, a, b, t};
  endfunction

  task automatic prog(input logic [3:0] addr, input logic [10:0] w);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_gate = w;
    @(negedge clk);
    prog_we   = 1'b0;
  endtask

  // Pulses start, then counts cycles until done_out (bounded)
  task automatic run(input logic [7:0] sin, input logic [4:0] n, input logic r,
                     output logic [7:0] sout, output int cyc, output logic busy_seen,
                     output logic err_v);
    @(negedge clk);
    state_in  = sin;
    num_gates = n;
    rev       = r;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    cyc       = 1;
    busy_seen = busy;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      busy_seen |= busy;
    end
    sout  = state_out;
    err_v = err;
  endtask

  logic [7:0] so;
  int         cyc;
  logic       bs;
  logic       ev;
  int         dones;
  logic [7:0] frozen;

  initial begin
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_gate = '0; num_gates = '0;
    rev = 1'b0; start = 1'b0; step = 1'b1; state_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("reset_state", 32'(state_out), 32'h00);
    check_eq("reset_busy", 32'(busy), 32'h0);
    check_eq("reset_done", 32'(done), 32'h0);
    check_eq("reset_err", 32'(err), 32'h0);

    // OR program: c = a | b
    prog(4'd0, g(1'b0, 1'b0, 3'd0, 3'd0, 3'd0));
    prog(4'd1, g(1'b0, 1'b0, 3'd0, 3'd0, 3'd1));
    prog(4'd2, g(1'b0, 1'b0, 3'd0, 3'd0, 3'd2));
    prog(4'd3, g(1'b1, 1'b1, 3'd0, 3'd1, 3'd2));
    prog(4'd4, g(1'b0, 1'b0, 3'd0, 3'd0, 3'd0));
    prog(4'd5, g(1'b0, 1'b0, 3'd0, 3'd0, 3'd1));

    run(8'h01, 5'd6, 1'b0, so, cyc, bs, ev);
    check_eq("or_01_state", 32'(so), 32'h05);
    check_eq("or_01_cycles", 32'(cyc), 32'd7);
    check_eq("or_01_err", 32'(ev), 32'h0);
    check_eq("or_01_busy_seen", 32'(bs), 32'h1);
    @(negedge clk);
    check_eq("done_one_cycle", 32'(done), 32'h0);
    check_eq("result_held", 32'(state_out), 32'h05);

    run(8'h00, 5'd6, 1'b0, so, cyc, bs, ev);
    check_eq("or_00_state", 32'(so), 32'h00);
    run(8'h02, 5'd6, 1'b0, so, cyc, bs, ev);
    check_eq("or_02_state", 32'(so), 32'h06);
    run(8'h03, 5'd6, 1'b0, so, cyc, bs, ev);
    check_eq("or_03_state", 32'(so), 32'h07);
    check_eq("or_03_cycles", 32'(cyc), 32'd7);

    run(8'h05, 5'd6, 1'b1, so, cyc, bs, ev);
    check_eq("rev_05_state", 32'(so), 32'h01);
    check_eq("rev_05_cycles", 32'(cyc), 32'd7);
    run(8'h07, 5'd6, 1'b1, so, cyc, bs, ev);
    check_eq("rev_07_state", 32'(so), 32'h03);

    run(8'hA5, 5'd0, 1'b0, so, cyc, bs, ev);
    check_eq("n0_state", 32'(so), 32'hA5);
    check_eq("n0_cycles", 32'(cyc), 32'd1);
    check_eq("n0_busy_seen", 32'(bs), 32'h0);

    // Slot 1 becomes CNOT with control == target
    prog(4'd1, g(1'b1, 1'b0, 3'd3, 3'd0, 3'd3));
    run(8'h00, 5'd3, 1'b0, so, cyc, bs, ev);
    check_eq("illegal_state", 32'(so), 32'h05);
    check_eq("illegal_err", 32'(ev), 32'h1);
    check_eq("illegal_cycles", 32'(cyc), 32'd4);
    prog(4'd1, g(1'b0, 1'b0, 3'd0, 3'd0, 3'd1));
    run(8'h01, 5'd6, 1'b0, so, cyc, bs, ev);
    check_eq("err_cleared", 32'(ev), 32'h0);
    check_eq("restored_state", 32'(so), 32'h05);

    // Reset during the second RUN cycle
    @(negedge clk);
    state_in = 8'h01; num_gates = 5'd6; rev = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrun_rst_state", 32'(state_out), 32'h00);
    check_eq("midrun_rst_busy", 32'(busy), 32'h0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      dones += int'(done);
      @(negedge clk);
    end
    check_eq("midrun_rst_no_done", 32'(dones), 32'd0);
    run(8'h02, 5'd6, 1'b0, so, cyc, bs, ev);
    check_eq("after_rst_state", 32'(so), 32'h06);

    // start and program write during RUN must be ignored
    @(negedge clk);
    state_in = 8'h01; num_gates = 5'd6; rev = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 100) begin
      if (cyc == 2) begin
        start = 1'b1; state_in = 8'hFF; num_gates = 5'd0;
        prog_we = 1'b1; prog_addr = 4'd0; prog_gate = g(1'b0, 1'b0, 3'd0, 3'd0, 3'd7);
      end else begin
        start = 1'b0; prog_we = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; prog_we = 1'b0;
    check_eq("guard_state", 32'(state_out), 32'h05);
    check_eq("guard_cycles", 32'(cyc), 32'd7);
    run(8'h00, 5'd6, 1'b0, so, cyc, bs, ev);
    check_eq("guard_slot0_kept", 32'(so), 32'h00);

`ifdef TOFF_STEP_EN
    // Hold step low for five cycles mid-run
    @(negedge clk);
    state_in = 8'h01; num_gates = 5'd6; rev = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    frozen = '0;
    while (!done && cyc < 100) begin
      if (cyc == 3) frozen = state_out;
      if (cyc == 8) check_eq("step_frozen", 32'(state_out), 32'(frozen));
      step = !(cyc >= 3 && cyc <= 7);
      @(negedge clk);
      cyc++;
    end
    step = 1'b1;
    check_eq("step_state", 32'(state_out), 32'h05);
    check_eq("step_cycles", 32'(cyc), 32'd12);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
